// File: rtl/gat_host_bridge.sv
// gat_host_bridge
//   Bridges one byte-addressed 32-bit host BRAM port onto NUM_CH word-addressed
//   accelerator BRAM channels, and sequences the accelerator core through its
//   load / start / busy phases.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   host_en/we/addr/din host request; addr = {channel, word, 2'b byte offset}
//   host_dout/rvalid    read data and its one-cycle strobe (RD_LAT+2 after request)
//   host_err / err_clr  sticky rejected-access flag and its clear
//   ch_en/we/addr/din   registered per-channel BRAM controls (flattened slots)
//   ch_dout             per-channel BRAM read data (flattened slots)
//   ch_load_done        per-channel level load-done indications
//   core_start          one-cycle start pulse, core_done completion pulse
//   busy, ready         core in START/BUSY, sticky result-ready flag

module gat_host_bridge #(
  parameter int                NUM_CH      = 4,
  parameter int                CH_DATA_W   = 16,
  parameter int                CH_ADDR_W   = 18,
  parameter int                RD_LAT      = 2,
  parameter bit                SIGNED_RD   = 1'b0,
  parameter logic [NUM_CH-1:0] LOAD_MASK   = {NUM_CH{1'b1}},
  parameter int                CH_SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int                HOST_ADDR_W = CH_SEL_W + CH_ADDR_W + 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          host_en,
  input  logic                          host_we,
  input  logic [HOST_ADDR_W-1:0]        host_addr,
  input  logic [31:0]                   host_din,
  output logic [31:0]                   host_dout,
  output logic                          host_rvalid,
  output logic                          host_err,
  input  logic                          err_clr,
  output logic [NUM_CH-1:0]             ch_en,
  output logic [NUM_CH-1:0]             ch_we,
  output logic [NUM_CH*CH_ADDR_W-1:0]   ch_addr,
  output logic [NUM_CH*CH_DATA_W-1:0]   ch_din,
  input  logic [NUM_CH*CH_DATA_W-1:0]   ch_dout,
  input  logic [NUM_CH-1:0]             ch_load_done,
  output logic                          core_start,
  input  logic                          core_done,
  output logic                          busy,
  output logic                          ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_BUSY  = 2'd3
  } state_t;

  // Channel count widened by one bit so the range check also works when
  // NUM_CH is a power of two and every select code is legal.
  localparam logic [CH_SEL_W:0] NUM_CH_W = NUM_CH[CH_SEL_W:0];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [CH_SEL_W-1:0]  req_ch;
  logic [CH_ADDR_W-1:0] req_word;
  logic [CH_DATA_W-1:0] req_data;
  logic                 req_ch_ok;
  logic                 fsm_locked;
  logic                 acc_ok;
  logic                 acc_rej;
  logic                 wr_acc;
  logic                 rd_req;
  logic                 unused_ok;

  state_t state_q, state_d;

  assign req_ch     = host_addr[HOST_ADDR_W-1 -: CH_SEL_W];
  assign req_word   = host_addr[CH_ADDR_W+1:2];
  assign req_data   = host_din[CH_DATA_W-1:0];
  assign req_ch_ok  = ({1'b0, req_ch} < NUM_CH_W);
  assign fsm_locked = (state_q == ST_START) || (state_q == ST_BUSY);
  // Reads always pass; writes are blocked while the core owns the memories.
  assign acc_ok     = host_en && req_ch_ok && (!host_we || !fsm_locked);
  assign acc_rej    = host_en && !acc_ok;
  assign wr_acc     = acc_ok && host_we;
  assign rd_req     = host_en && !host_we;

  // Byte-offset bits and truncated write-data bits are intentionally dropped.
  assign unused_ok  = &{1'b0, host_addr[1:0], host_din};

  // ---------------------------------------------------------------------------
  // Per-channel registered BRAM controls
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]           ch_en_q,   ch_en_d;
  logic [NUM_CH-1:0]           ch_we_q,   ch_we_d;
  logic [NUM_CH*CH_ADDR_W-1:0] ch_addr_q, ch_addr_d;
  logic [NUM_CH*CH_DATA_W-1:0] ch_din_q,  ch_din_d;
  logic [CH_DATA_W-1:0]        ch_dout_arr [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic sel;
    assign sel = acc_ok && (req_ch == CH_SEL_W'(gi));
    assign ch_en_d[gi] = sel;
    assign ch_we_d[gi] = sel && host_we;
    // Unselected slots keep their last address/data so idle channels do not toggle.
    assign ch_addr_d[gi*CH_ADDR_W +: CH_ADDR_W] =
      sel ? req_word : ch_addr_q[gi*CH_ADDR_W +: CH_ADDR_W];
    assign ch_din_d[gi*CH_DATA_W +: CH_DATA_W] =
      sel ? req_data : ch_din_q[gi*CH_DATA_W +: CH_DATA_W];
    assign ch_dout_arr[gi] = ch_dout[gi*CH_DATA_W +: CH_DATA_W];
  end

  // ---------------------------------------------------------------------------
  // Read return pipe
  //   stage 0 lines up with the registered ch_en; stage RD_LAT lines up with
  //   the cycle in which the BRAM presents data. One select stage and one
  //   output stage follow, giving RD_LAT+2 from request to rvalid.
  // ---------------------------------------------------------------------------
  logic [RD_LAT:0]               rd_vld_q, rd_vld_d;
  logic [RD_LAT:0]               rd_ok_q,  rd_ok_d;
  logic [RD_LAT:0][CH_SEL_W-1:0] rd_ch_q,  rd_ch_d;
  logic                          sel_vld_q, sel_vld_d;
  logic [CH_DATA_W-1:0]          sel_data_q, sel_data_d;
  logic [31:0]                   host_dout_q, host_dout_d;
  logic                          host_rvalid_q, host_rvalid_d;
  logic [CH_DATA_W-1:0]          sel_raw;
  logic [31:0]                   sel_ext;

  always_comb begin
    rd_vld_d    = '0;
    rd_ok_d     = '0;
    rd_ch_d     = '0;
    rd_vld_d[0] = rd_req;
    rd_ok_d[0]  = rd_req && req_ch_ok;
    rd_ch_d[0]  = req_ch;
    for (int k = 1; k <= RD_LAT; k++) begin
      rd_vld_d[k] = rd_vld_q[k-1];
      rd_ok_d[k]  = rd_ok_q[k-1];
      rd_ch_d[k]  = rd_ch_q[k-1];
    end
  end

  always_comb begin
    sel_raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch_q[RD_LAT] == CH_SEL_W'(i)) begin
        sel_raw = ch_dout_arr[i];
      end
    end
    sel_vld_d = rd_vld_q[RD_LAT];
    // Invalid-channel reads still return a slot, carrying zero.
    sel_data_d = rd_ok_q[RD_LAT] ? sel_raw : '0;
  end

  always_comb begin
    if (SIGNED_RD) begin
      sel_ext = 32'($signed(sel_data_q));
    end else begin
      sel_ext = 32'(sel_data_q);
    end
    host_rvalid_d = sel_vld_q;
    host_dout_d   = sel_vld_q ? sel_ext : host_dout_q;
  end

  // ---------------------------------------------------------------------------
  // Core sequencing, load flags, status flags
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] done_flag_q, done_flag_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              flags_met;

  assign flags_met = ((done_flag_q & LOAD_MASK) == LOAD_MASK);

  always_comb begin
    state_d     = state_q;
    done_flag_d = done_flag_q | ch_load_done;
    ready_d     = ready_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_acc) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (flags_met) begin
          state_d     = ST_START;
          done_flag_d = '0;
        end
      end
      ST_START: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (core_done) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Writes cannot be accepted in BUSY, so this never collides with the set above.
    if (wr_acc) ready_d = 1'b0;
    // A new rejection in the same cycle as a clear keeps the flag set.
    err_d = acc_rej || (err_q && !err_clr);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      done_flag_q   <= '0;
      err_q         <= 1'b0;
      ready_q       <= 1'b0;
      ch_en_q       <= '0;
      ch_we_q       <= '0;
      ch_addr_q     <= '0;
      ch_din_q      <= '0;
      rd_vld_q      <= '0;
      rd_ok_q       <= '0;
      rd_ch_q       <= '0;
      sel_vld_q     <= 1'b0;
      sel_data_q    <= '0;
      host_dout_q   <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_flag_q   <= done_flag_d;
      err_q         <= err_d;
      ready_q       <= ready_d;
      ch_en_q       <= ch_en_d;
      ch_we_q       <= ch_we_d;
      ch_addr_q     <= ch_addr_d;
      ch_din_q      <= ch_din_d;
      rd_vld_q      <= rd_vld_d;
      rd_ok_q       <= rd_ok_d;
      rd_ch_q       <= rd_ch_d;
      sel_vld_q     <= sel_vld_d;
      sel_data_q    <= sel_data_d;
      host_dout_q   <= host_dout_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign host_dout   = host_dout_q;
  assign host_rvalid = host_rvalid_q;
  assign host_err    = err_q;
  assign ch_en       = ch_en_q;
  assign ch_we       = ch_we_q;
  assign ch_addr     = ch_addr_q;
  assign ch_din      = ch_din_q;
  assign core_start  = (state_q == ST_START);
  assign busy        = fsm_locked;
  assign ready       = ready_q;

endmodule

// File: tb/tb_gat_host_bridge.sv
// Testbench for gat_host_bridge.
//   u_a: default parameters (4 channels, 16-bit data, RD_LAT 2, zero-extend).
//   u_b: 3 channels, sign-extended reads.
// Each instance sees a small behavioural BRAM per channel with a 2-cycle read
// latency. Read expectations are queued when a read is issued and checked by
// a per-instance monitor when host_rvalid appears, including arrival cycle.

module tb_gat_host_bridge;

  localparam int AW = 22;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en_a, en_b, host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_din;
  logic          err_clr_a, err_clr_b, core_done_a, core_done_b;
  logic [3:0]    ld_a;
  logic [2:0]    ld_b;

  logic [31:0] a_dout, b_dout;
  logic        a_rvalid, b_rvalid, a_err, b_err;
  logic        a_start, b_start, a_busy, b_busy, a_ready, b_ready;
  logic [3:0]  a_ch_en, a_ch_we;
  logic [71:0] a_ch_addr;
  logic [63:0] a_ch_din, a_ch_dout, pa1_a;
  logic [2:0]  b_ch_en, b_ch_we;
  logic [53:0] b_ch_addr;
  logic [47:0] b_ch_din, b_ch_dout, pa1_b;

  logic [15:0] mem_a [4][256];
  logic [15:0] mem_b [3][256];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  gat_host_bridge u_a (
    .clk(clk), .rst(rst),
    .host_en(en_a), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_dout(a_dout), .host_rvalid(a_rvalid), .host_err(a_err), .err_clr(err_clr_a),
    .ch_en(a_ch_en), .ch_we(a_ch_we), .ch_addr(a_ch_addr), .ch_din(a_ch_din),
    .ch_dout(a_ch_dout), .ch_load_done(ld_a),
    .core_start(a_start), .core_done(core_done_a), .busy(a_busy), .ready(a_ready)
  );

  gat_host_bridge #(.NUM_CH(3), .SIGNED_RD(1'b1)) u_b (
    .clk(clk), .rst(rst),
    .host_en(en_b), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_dout(b_dout), .host_rvalid(b_rvalid), .host_err(b_err), .err_clr(err_clr_b),
    .ch_en(b_ch_en), .ch_we(b_ch_we), .ch_addr(b_ch_addr), .ch_din(b_ch_din),
    .ch_dout(b_ch_dout), .ch_load_done(ld_b),
    .core_start(b_start), .core_done(core_done_b), .busy(b_busy), .ready(b_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural write-first BRAMs, two-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (a_ch_en[i]) begin
        if (a_ch_we[i]) begin
          mem_a[i][a_ch_addr[i*18 +: 8]] <= a_ch_din[i*16 +: 16];
          pa1_a[i*16 +: 16] <= a_ch_din[i*16 +: 16];
        end else begin
          pa1_a[i*16 +: 16] <= mem_a[i][a_ch_addr[i*18 +: 8]];
        end
      end
    end
    a_ch_dout <= pa1_a;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (b_ch_en[i]) begin
        if (b_ch_we[i]) begin
          mem_b[i][b_ch_addr[i*18 +: 8]] <= b_ch_din[i*16 +: 16];
          pa1_b[i*16 +: 16] <= b_ch_din[i*16 +: 16];
        end else begin
          pa1_b[i*16 +: 16] <= mem_b[i][b_ch_addr[i*18 +: 8]];
        end
      end
    end
    b_ch_dout <= pa1_b;
  end

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (a_rvalid) begin
      n_checks++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_rvalid_unexpected: got rvalid dout=%h at cycle %0d, required no rvalid", a_dout, cyc);
      end else begin
        e_a = q_a.pop_front();
        if (a_dout !== e_a.data || cyc != e_a.due) begin
          n_fail++;
          $display("FAIL a_read: got %h at cycle %0d, required %h at cycle %0d", a_dout, cyc, e_a.data, e_a.due);
        end else begin
          $display("rd A data=%h cycle=%0d ok", a_dout, cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_rvalid) begin
      n_checks++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_rvalid_unexpected: got rvalid dout=%h at cycle %0d, required no rvalid", b_dout, cyc);
      end else begin
        e_b = q_b.pop_front();
        if (b_dout !== e_b.data || cyc != e_b.due) begin
          n_fail++;
          $display("FAIL b_read: got %h at cycle %0d, required %h at cycle %0d", b_dout, cyc, e_b.data, e_b.due);
        end else begin
          $display("rd B data=%h cycle=%0d ok", b_dout, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] ha(input int ch, input int w);
    ha = AW'((ch << 20) | (w << 2));
  endfunction

  task automatic issue(input bit inst_b, input bit we, input int ch, input int w, input logic [31:0] din);
    en_a      = !inst_b;
    en_b      = inst_b;
    host_we   = we;
    host_addr = ha(ch, w);
    host_din  = din;
  endtask

  task automatic idle();
    en_a    = 1'b0;
    en_b    = 1'b0;
    host_we = 1'b0;
  endtask

  // Called in the cycle the read is driven: sampled at the next edge, so
  // rvalid shows up at cycle cyc + 1 + 4.
  task automatic expect_rd(input bit inst_b, input logic [31:0] data);
    exp_t e;
    e.data = data;
    e.due  = cyc + 5;
    if (inst_b) q_b.push_back(e);
    else        q_a.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    host_addr = '0; host_din = '0;
    err_clr_a = 0; err_clr_b = 0; core_done_a = 0; core_done_b = 0;
    ld_a = '0; ld_b = '0;

    // Reset state.
    ticks(2);
    chk("reset_a_ch_en",  32'(a_ch_en), 0);
    chk("reset_a_dout",   a_dout, 0);
    chk("reset_a_status", {27'd0, a_rvalid, a_err, a_start, a_busy, a_ready}, 0);
    chk("reset_b_status", {27'd0, b_rvalid, b_err, b_start, b_busy, b_ready}, 0);
    rst = 1'b0;
    tick();

    // Write ch2 word 5 on A.
    issue(0, 1, 2, 5, 32'h0001_ABCD);
    tick();
    chk("wr_a_ch_en",     32'(a_ch_en), 32'h4);
    chk("wr_a_ch_we",     32'(a_ch_we), 32'h4);
    chk("wr_a_ch_addr2",  32'(a_ch_addr[2*18 +: 18]), 5);
    chk("wr_a_ch_din2",   32'(a_ch_din[2*16 +: 16]), 32'hABCD);
    chk("wr_a_err",       32'(a_err), 0);
    issue(0, 1, 0, 1, 32'h0000_1111); tick();
    issue(0, 1, 1, 2, 32'h0000_2222); tick();
    issue(0, 1, 3, 3, 32'hDEAD_8333); tick();
    idle();
    tick();

    // Single read, then four back-to-back reads across channels.
    issue(0, 0, 2, 5, 0); expect_rd(0, 32'h0000_ABCD); tick();
    idle(); ticks(6);
    issue(0, 0, 0, 1, 0); expect_rd(0, 32'h0000_1111); tick();
    issue(0, 0, 1, 2, 0); expect_rd(0, 32'h0000_2222); tick();
    issue(0, 0, 3, 3, 0); expect_rd(0, 32'h0000_8333); tick();
    issue(0, 0, 0, 1, 0); expect_rd(0, 32'h0000_1111); tick();
    idle(); ticks(6);

    // Write then read the same address on consecutive cycles.
    issue(0, 1, 1, 7, 32'h0000_7777); tick();
    issue(0, 0, 1, 7, 0); expect_rd(0, 32'h0000_7777); tick();
    idle(); ticks(6);

    // Instance B: sign extension and invalid channel 3.
    issue(1, 1, 2, 5, 32'h0001_ABCD); tick();
    chk("wr_b_ch_en", 32'(b_ch_en), 32'h4);
    issue(1, 0, 2, 5, 0); expect_rd(1, 32'hFFFF_ABCD); tick();
    idle(); ticks(6);
    issue(1, 1, 3, 0, 32'h1234); tick();
    chk("inv_wr_b_ch_en", 32'(b_ch_en), 0);
    chk("inv_wr_b_err",   32'(b_err), 1);
    idle();
    err_clr_b = 1; tick(); err_clr_b = 0;
    chk("errclr_b", 32'(b_err), 0);
    issue(1, 0, 3, 0, 0); expect_rd(1, 32'h0); err_clr_b = 1; tick();
    chk("inv_rd_b_ch_en", 32'(b_ch_en), 0);
    chk("set_wins_b_err", 32'(b_err), 1);
    idle(); err_clr_b = 0; ticks(6);
    err_clr_b = 1; tick(); err_clr_b = 0;
    chk("errclr2_b", 32'(b_err), 0);

    // A core sequencing; A is in LOAD after the earlier writes.
    ld_a = 4'b0111; ticks(3);
    chk("partial_ld_start", 32'(a_start), 0);
    chk("partial_ld_busy",  32'(a_busy), 0);
    ld_a = 4'b1111; tick();
    chk("ld_flag_cycle_start", 32'(a_start), 0);
    tick();
    chk("start_pulse", 32'(a_start), 1);
    chk("start_busy",  32'(a_busy), 1);
    ld_a = 4'b0000; tick();
    chk("start_one_cycle", 32'(a_start), 0);
    chk("busy_hold",       32'(a_busy), 1);
    chk("busy_ready",      32'(a_ready), 0);
    issue(0, 1, 0, 9, 32'h5555); tick();
    chk("busy_wr_ch_en", 32'(a_ch_en), 0);
    chk("busy_wr_err",   32'(a_err), 1);
    issue(0, 0, 2, 5, 0); expect_rd(0, 32'h0000_ABCD); tick();
    chk("busy_rd_ch_en", 32'(a_ch_en), 32'h4);
    idle(); err_clr_a = 1; tick(); err_clr_a = 0;
    chk("errclr_a", 32'(a_err), 0);
    core_done_a = 1; tick(); core_done_a = 0;
    chk("done_busy",  32'(a_busy), 0);
    chk("done_ready", 32'(a_ready), 1);
    ticks(2);
    core_done_a = 1; tick(); core_done_a = 0;
    chk("stray_done_ready", 32'(a_ready), 1);
    chk("stray_done_start", 32'(a_start), 0);
    issue(0, 1, 0, 9, 32'h5555); tick();
    chk("wr_clears_ready", 32'(a_ready), 0);
    chk("wr_after_done_en", 32'(a_ch_en), 32'h1);
    idle(); ticks(6);

    // Reset with two reads in flight: nothing may come back.
    issue(0, 0, 0, 1, 0); tick();
    issue(0, 0, 1, 2, 0); tick();
    idle();
    rst = 1'b1; #1;
    chk("rst_mid_rvalid", 32'(a_rvalid), 0);
    chk("rst_mid_dout",   a_dout, 0);
    chk("rst_mid_ch",     {30'd0, a_ch_addr != '0, a_ch_en != '0}, 0);
    chk("rst_mid_status", {28'd0, a_err, a_start, a_busy, a_ready}, 0);
    ticks(3);
    rst = 1'b0;
    ticks(8);
    // After reset the FSM is IDLE: full load flags alone must not start it.
    ld_a = 4'b1111; ticks(4);
    chk("rst_idle_no_start", {30'd0, a_start, a_busy}, 0);
    ld_a = 4'b0000; ticks(2);

    chk("scoreboard_a_empty", 32'(q_a.size()), 0);
    chk("scoreboard_b_empty", 32'(q_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gat_host_bridge.md
# gat_host_bridge

Parametrised host-side bridge between a single byte-addressed host BRAM port and NUM_CH word-addressed accelerator BRAM channels. It decodes channel select from upper address bits and strips byte-offset bits. It pipelines reads with a configurable BRAM latency and tracks per-channel load-done flags. It sequences the accelerator core through load, start and busy phases, replacing fixed per-port address slicing with a generic, checked, latency-aware path.

## Interface

Parameters:
- NUM_CH, 4: number of BRAM channels (1..16).
- CH_DATA_W, 16: channel data width (1..32).
- CH_ADDR_W, 18: channel word-address width.
- RD_LAT, 2: channel BRAM read latency in cycles (1..4).
- SIGNED_RD, 0: 1 sign-extends read data to 32 bits, 0 zero-extends.
- LOAD_MASK, {NUM_CH{1'b1}}: channels whose load-done is required before start.
- CH_SEL_W, max(1,$clog2(NUM_CH)): derived.
- HOST_ADDR_W, CH_SEL_W+CH_ADDR_W+2: derived.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- host_en  in  1  access request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  HOST_ADDR_W  byte address: [1:0] ignored, [CH_ADDR_W+1:2] word address, [HOST_ADDR_W-1:CH_ADDR_W+2] channel.
- host_din  in  32  write data.
- host_dout  out  32  read data.
- host_rvalid  out  1  one-cycle read-data strobe.
- host_err  out  1  sticky error flag.
- err_clr  in  1  clears host_err.
- ch_en, ch_we  out  NUM_CH  per-channel enable / write enable.
- ch_addr  out  NUM_CH*CH_ADDR_W  flattened word addresses; channel i at [i*CH_ADDR_W +: CH_ADDR_W].
- ch_din  out  NUM_CH*CH_DATA_W  flattened write data.
- ch_dout  in  NUM_CH*CH_DATA_W  flattened read data.
- ch_load_done  in  NUM_CH  level load-done from the register bank.
- core_start  out  1  one-cycle start pulse to the core.
- core_done  in  1  core completion pulse.
- busy  out  1  high in START and BUSY.
- ready  out  1  sticky result-ready flag.

## Operation

- Request decode:
  - ch = host_addr channel field; valid iff ch < NUM_CH.
  - Valid request: drive ch_en[ch], ch_we[ch], ch_addr slot = word address, ch_din slot = host_din[CH_DATA_W-1:0] (truncated).
  - Other channels have en/we = 0. Address and data slots of non-selected channels hold their previous values.
- Writes:
  - Rejected (no ch_en, host_err set) when ch is invalid or the FSM is in START or BUSY.
  - Any accepted write clears ready.
- Reads:
  - Allowed in every state.
  - The channel index and a valid bit travel down an RD_LAT-deep pipe. At the end, the selected ch_dout slot is extended per SIGNED_RD, registered into host_dout, and host_rvalid is pulsed.
  - Invalid-channel read: no ch_en, host_err set; host_dout = 0 with host_rvalid still pulsed at the normal slot.
- Load flags:
  - done_flag[i] is set while ch_load_done[i] is high.
  - All flags clear on entering START.
- FSM:
  - IDLE -> LOAD on the first accepted write.
  - LOAD -> START when (done_flag & LOAD_MASK) == LOAD_MASK.
  - START -> BUSY after 1 cycle; core_start = 1 only in START.
  - BUSY -> IDLE on core_done, which sets ready.
  - core_done outside BUSY is ignored.
  - LOAD_MASK = 0 still requires one write to leave IDLE.
- host_err: set on any rejected access; cleared by err_clr. If set and clear coincide, set wins.

## Timing

- Reset:
  - All outputs 0.
  - FSM = IDLE; done flags, error flag, ready and read pipe cleared.
  - In-flight reads are discarded: no rvalid after reset, including reset mid-read.
- Request to channel: ch_* outputs are registered, asserted 1 cycle after the host_en sample.
- Read latency: host_en sample to host_rvalid = RD_LAT + 2 cycles, fully pipelined. Back-to-back reads on any mix of channels give one rvalid per cycle, in order.
- Write-then-read to the same address on consecutive cycles returns the new data; BRAM write-first behaviour is assumed at the channel.
- START is entered the cycle after the flag condition first holds. A write in that same LOAD cycle is still accepted.

## Test plan

- RD_LAT=2: write 0x0001_ABCD to channel 2, word 5 (host_addr = (2<<20)|(5<<2)) -> ch_en = 4'b0100, ch_we[2] = 1, ch_addr slot 2 = 5, ch_din slot 2 = 0xABCD, one cycle later. Read back -> host_rvalid 4 cycles after host_en, host_dout = 0x0000_ABCD; with SIGNED_RD = 1 -> 0xFFFF_ABCD.
- Reads to ch0, ch1, ch3, ch0 on 4 consecutive cycles -> 4 consecutive rvalids with matching data, in order.
- NUM_CH=3, access to channel 3 -> no ch_en, host_err = 1. A read still yields rvalid with dout 0. Assert err_clr -> host_err = 0.
- Write once, then raise ch_load_done = 4'b0111 -> no start. Add bit 3 -> core_start pulse, busy = 1. A write during BUSY -> rejected, host_err = 1. core_done -> busy = 0, ready = 1. The next write clears ready.
- Assert rst with two reads in flight -> outputs 0, no rvalid, FSM IDLE.
